// File: rtl/aidan_mcnay_shift_mul.sv
// aidan_mcnay_shift_mul: iterative shift-add unsigned multiplier, val/rdy in and out.
// Handles one multiplier bit per CALC cycle and exits early once the remaining multiplier bits are zero.
module aidan_mcnay_shift_mul #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] opa,
  input  logic [nbits-1:0] opb,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] result,
  output logic             ostream_val,
  input  logic             ostream_rdy
);
  localparam int CW = $clog2(nbits);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [nbits-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             last;
  assign last = (b_q[nbits-1:1] == '0) || (count_q == CW'(nbits - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  // handshake inputs are only looked at in the state where they matter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (istream_val) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (ostream_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (state_q == IDLE && istream_val) begin
      a_d     = opa;
      b_d     = opb;
      acc_d   = '0;
      count_d = '0;
    end else if (state_q == CALC) begin
      acc_d   = b_q[0] ? acc_q + a_q : acc_q;
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      count_d = count_q + 1'b1;
    end
  end
  always_comb begin
    istream_rdy = (state_q == IDLE);
    ostream_val = (state_q == DONE);
    result      = acc_q;
  end
endmodule
